// File: rtl/mem_responder_pkg.sv
// Shared widths, size codes, FSM states and byte-enable helper for the memory responder.
package mem_responder_pkg;

   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;

   localparam logic [3:0] SIZE_BYTE = 4'b0001;
   localparam logic [3:0] SIZE_HALF = 4'b0010;
   localparam logic [3:0] SIZE_WORD = 4'b1000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Illegal size codes yield no lanes, so they can never write anything.
   function automatic logic [3:0] byte_en(input logic [3:0] size, input logic [1:0] off);
      case (size)
         SIZE_BYTE: return 4'b0001 << off;
         SIZE_HALF: return 4'b0011 << off;
         SIZE_WORD: return 4'b1111;
         default:   return 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// Word-organised storage with per-byte write enables and a combinational read port.
module mem_array #(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                           clock,
   input  logic                           we,
   input  logic [3:0]                     be,
   input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
   input  logic [31:0]                    wdata,
   output logic [31:0]                    rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clock) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: fixed-latency request/response FSM with
// alignment/range checking and byte-lane steering around a mem_array.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wr,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [3:0]            req_size,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err
);

   localparam int WA_W = $clog2(DEPTH_WORDS);

   state_t                state, state_nx;
   logic [3:0]            cnt;
   logic                  wr_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [3:0]            size_q;

   logic                  accept, do_access;
   logic                  acc_wr;
   logic [ADDR_WIDTH-1:0] acc_addr;
   logic [DATA_WIDTH-1:0] acc_wdata;
   logic [3:0]            acc_size;
   logic                  hi_bad, size_bad, misalign, err;
   logic [31:0]           mem_rdata, lane, rd_val;

   assign accept = (state == ST_IDLE) && req_ready && req_valid;

   // With LATENCY=1 the access happens on the accept edge, straight from the request bus.
   assign acc_wr    = (state == ST_IDLE) ? req_wr    : wr_q;
   assign acc_addr  = (state == ST_IDLE) ? req_addr  : addr_q;
   assign acc_wdata = (state == ST_IDLE) ? req_wdata : wdata_q;
   assign acc_size  = (state == ST_IDLE) ? req_size  : size_q;

   // The counter reaches 0 on the same edge that performs the access.
   assign do_access = (accept && LATENCY == 1) || (state == ST_WAIT && cnt == 4'd1);

   assign hi_bad   = acc_addr[ADDR_WIDTH-1:WA_W+2] != '0;
   assign size_bad = !(acc_size == SIZE_BYTE || acc_size == SIZE_HALF || acc_size == SIZE_WORD);
   assign misalign = (acc_size == SIZE_HALF && acc_addr[0]) ||
                     (acc_size == SIZE_WORD && acc_addr[1:0] != 2'b00);
   assign err      = hi_bad || size_bad || misalign;

   mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_mem (
      .clock (clock),
      .we    (do_access && acc_wr && !err),
      .be    (byte_en(acc_size, acc_addr[1:0])),
      .addr  (acc_addr[WA_W+1:2]),
      .wdata (acc_wdata),
      .rdata (mem_rdata)
   );

   assign lane = mem_rdata >> {acc_addr[1:0], 3'b000};

   always_comb begin
      rd_val = '0;
      if (!err && !acc_wr) begin
         case (acc_size)
            SIZE_BYTE: rd_val = {24'b0, lane[7:0]};
            SIZE_HALF: rd_val = {16'b0, lane[15:0]};
            default:   rd_val = mem_rdata;
         endcase
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (accept) state_nx = (LATENCY == 1) ? ST_RESP : ST_WAIT;
         ST_WAIT: if (cnt == 4'd1) state_nx = ST_RESP;
         ST_RESP: if (resp_ready) state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         cnt        <= 4'd0;
         req_ready  <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         state     <= state_nx;
         req_ready <= (state_nx == ST_IDLE);
         if (accept) cnt <= 4'(LATENCY - 1);
         else if (state == ST_WAIT) cnt <= cnt - 4'd1;
         if (do_access) begin
            resp_rdata <= rd_val;
            resp_err   <= err;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (accept) begin
         wr_q    <= req_wr;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
         size_q  <= req_size;
      end
   end

   assign resp_valid = (state == ST_RESP);

endmodule
